mux_rr_nx1: RTL
===============

Name: mux_rr_nx1

Overview:
- Parametrised N-channel to 1 multiplexer with a registered output and a valid/ready handshake on every port.
- Two modes:
  - Fixed-select: the channel is chosen by the sel input, like the combinational 4:1 mux.
  - Round-robin: the block arbitrates fairly among all requesting channels.
- Sits between multiple producer channels and a single downstream consumer. Sustains one transfer per cycle.

Parameters:
- N_CH, 4, number of input channels (>=2)
- DW, 8, data width per channel
- SELW, $clog2(N_CH), width of the select and channel-tag fields

Ports:
- clk  input  1  single clock, rising-edge
- rst  input  1  reset, asynchronous, active-high
- in_data  input  N_CH*DW  channel i data at bits [i*DW +: DW]
- in_valid  input  N_CH  per-channel request
- in_ready  output  N_CH  per-channel accept (combinational)
- mode  input  1  0 = fixed-select, 1 = round-robin
- sel  input  SELW  channel select, used only when mode=0
- out_data  output  DW  registered selected data
- out_ch  output  SELW  index of the channel that supplied out_data
- out_valid  output  1  out_data/out_ch hold a valid beat
- out_ready  input  1  downstream accept

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - out_valid=0, out_data=0, out_ch=0.
  - Round-robin pointer rr_ptr=0.
  - in_ready: all 0 until the output register reports space (it does so immediately after reset).
- Output register space:
  - load = !out_valid | out_ready.
  - The register accepts a new beat whenever load is true, so full throughput is maintained while out_ready stays high.
- Grant, mode=0:
  - grant = sel when sel < N_CH and in_valid[sel]=1; otherwise no grant.
  - sel >= N_CH (possible when N_CH is not a power of 2) gives no grant and no transfer.
- Grant, mode=1:
  - Search channels rr_ptr, rr_ptr+1, ..., wrapping modulo N_CH.
  - The first channel with in_valid=1 wins; no valid requests means no grant.
- Handshake:
  - in_ready[g] = load & grant_valid, for the granted channel g only.
  - All other bits of in_ready are 0.
  - in_ready depends on in_valid, sel, mode, rr_ptr and out_valid/out_ready; it must not depend on in_data.
- Transfer on the clock edge with in_valid[g] & in_ready[g]:
  - out_data <= in_data[g], out_ch <= g, out_valid <= 1.
  - Latency is 1 cycle from accept to out_valid.
- Drain without refill: if load is true and there is no grant, out_valid <= 0 on that edge. out_data and out_ch hold their last values.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_ch and out_valid must stay stable, and all in_ready bits are 0.
- rr_ptr update:
  - Updated only on a transfer made in mode=1: rr_ptr <= (g+1) mod N_CH. The wrap from N_CH-1 goes to 0.
  - A mode=0 transfer leaves rr_ptr unchanged.
- Mode or sel change:
  - Sampled combinationally and takes effect on the next grant decision.
  - A beat already held in the output register is unaffected.
- Simultaneous drain and refill (out_valid=1, out_ready=1, grant present): the new beat replaces the old one on the same edge with no bubble.
- Reset mid-operation: any held beat is discarded, and out_valid drops asynchronously on rst assertion.

Test Plan:
1. Reset and fixed select (N_CH=4, DW=8):
   - Stimulus: assert rst and check out_valid=0, out_data=0. Release rst; mode=0, sel=2, in_data={8'h44,8'h33,8'h22,8'h11}, in_valid=4'b0100, out_ready=1.
   - Required: in_ready=4'b0100; next cycle out_data=8'h33, out_ch=2, out_valid=1.
2. Round-robin fairness:
   - Stimulus: mode=1, in_valid=4'b1111 held, out_ready=1.
   - Required: out_ch sequence 0,1,2,3,0,1 on consecutive cycles with no bubbles.
3. Round-robin skip and wrap:
   - Stimulus: mode=1, rr_ptr=3 (after granting ch2), in_valid=4'b0011.
   - Required: grant ch0 (wrap past ch3), then ch1, then ch0.
4. Backpressure:
   - Stimulus: out_valid=1 with out_data=8'hA5, then hold out_ready=0 for 3 cycles with in_valid=4'b1111.
   - Required: out_data=8'hA5 stable, in_ready=0 throughout. When out_ready=1, a new beat loads on the same edge.
5. Fixed-select miss and drain:
   - Stimulus: mode=0, sel=1, in_valid=4'b1101, out_valid=1, out_ready=1.
   - Required: in_ready=0; next cycle out_valid=0, out_data and out_ch unchanged.
6. Async reset mid-stream:
   - Stimulus: assert rst between clock edges during test 2.
   - Required: out_valid=0 immediately (before the next edge). After release, the first round-robin grant is ch0.

Source files
------------

// File: rtl/mux_rr_nx1.sv
// rtl/mux_rr_nx1.sv - N-channel to 1 registered mux with fixed-select and round-robin arbitration
module mux_rr_nx1 #(
  parameter int N_CH = 4,
  parameter int DW   = 8,
  parameter int SELW = $clog2(N_CH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CH*DW-1:0]   in_data,
  input  logic [N_CH-1:0]      in_valid,
  output logic [N_CH-1:0]      in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [DW-1:0]        out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready
);

  // Output register and round-robin pointer state
  logic              out_valid_q, out_valid_d;
  logic [DW-1:0]     out_data_q,  out_data_d;
  logic [SELW-1:0]   out_ch_q,    out_ch_d;
  logic [SELW-1:0]   rr_ptr_q,    rr_ptr_d;

  // Grant candidates from each mode, and the selected grant
  logic              fix_gnt_valid;
  logic [SELW-1:0]   fix_gnt_idx;
  logic              rr_gnt_valid;
  logic [SELW-1:0]   rr_gnt_idx;
  logic [SELW:0]     rr_cand;
  logic              gnt_valid;
  logic [SELW-1:0]   gnt_idx;
  logic [DW-1:0]     gnt_data;
  logic              load;

  // The output register can take a beat when it is empty or being drained this cycle
  assign load = !out_valid_q || out_ready;

  // Fixed-select grant: an out-of-range sel simply never matches a channel
  always_comb begin
    fix_gnt_valid = 1'b0;
    fix_gnt_idx   = sel;
    for (int i = 0; i < N_CH; i++) begin
      if ((sel == SELW'(i)) && in_valid[i]) begin
        fix_gnt_valid = 1'b1;
      end
    end
  end

  // Round-robin grant: walk outward from rr_ptr, first requester wins
  always_comb begin
    rr_gnt_valid = 1'b0;
    rr_gnt_idx   = '0;
    rr_cand      = '0;
    for (int k = 0; k < N_CH; k++) begin
      // rr_ptr is always < N_CH, so one subtraction folds the wrap back into range
      rr_cand = {1'b0, rr_ptr_q} + (SELW+1)'(k);
      if (rr_cand >= (SELW+1)'(N_CH)) begin
        rr_cand = rr_cand - (SELW+1)'(N_CH);
      end
      for (int i = 0; i < N_CH; i++) begin
        if (!rr_gnt_valid && in_valid[i] && (rr_cand == (SELW+1)'(i))) begin
          rr_gnt_valid = 1'b1;
          rr_gnt_idx   = SELW'(i);
        end
      end
    end
  end

  // Mode picks which grant is live; data is muxed only from the granted channel
  always_comb begin
    gnt_valid = mode ? rr_gnt_valid : fix_gnt_valid;
    gnt_idx   = mode ? rr_gnt_idx   : fix_gnt_idx;
    gnt_data  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (gnt_idx == SELW'(i)) begin
        gnt_data = in_data[i*DW +: DW];
      end
    end
  end

  // Only the granted channel sees ready, and only when the output register has space
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N_CH; i++) begin
      in_ready[i] = load && gnt_valid && (gnt_idx == SELW'(i));
    end
  end

  // Next-state: load on grant, drain to empty without one, hold under backpressure
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      out_valid_d = gnt_valid;
      if (gnt_valid) begin
        out_data_d = gnt_data;
        out_ch_d   = gnt_idx;
        // Pointer only advances on round-robin transfers; fixed-select leaves it alone
        if (mode) begin
          rr_ptr_d = (gnt_idx == SELW'(N_CH-1)) ? '0 : gnt_idx + SELW'(1);
        end
      end
    end
  end

  // State registers with asynchronous reset discarding any held beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule
